// File: rtl/operand_fetch_stage_if.sv
// Handshake and register-file bundle for the operand fetch stage.
// slave is the stage's view; master is the surrounding datapath / bench.
interface operand_fetch_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [2:0]  rf_readA_addr;
  logic [2:0]  rf_readB_addr;
  logic [15:0] rf_reg_A;
  logic [15:0] rf_reg_B;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [2:0]  out_rd;
  logic [15:0] out_opA;
  logic [15:0] out_opB;
  logic [15:0] out_imm;

  modport slave (
    input  in_valid, instr, rf_reg_A, rf_reg_B, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, rf_readA_addr, rf_readB_addr,
           out_valid, out_op, out_rd, out_opA, out_opB, out_imm
  );

  modport master (
    output in_valid, instr, rf_reg_A, rf_reg_B, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, rf_readA_addr, rf_readB_addr,
           out_valid, out_op, out_rd, out_opA, out_opB, out_imm
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch: drives sync-read regfile addresses, waits out read latency,
// captures operands with write-port bypass, and holds a decoded bundle.
module operand_fetch_stage #(
  parameter bit IMM_SIGNED = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  operand_fetch_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [15:0] pdat_a_q, pdat_a_d, pdat_b_q, pdat_b_d;
  logic        vld_q, vld_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  rd_q, rd_d;
  logic [15:0] opa_q, opa_d, opb_q, opb_d, imm_q, imm_d;

  logic [2:0]  rs, rt;
  logic        in_ready, accept, hit_a, hit_b;
  logic [15:0] imm_ext;

  assign rs       = instr_q[8:6];
  assign rt       = instr_q[5:3];
  assign in_ready = (state_q == IDLE) || (state_q == HOLD && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign hit_a    = bus.wb_we && (bus.wb_addr == rs);
  assign hit_b    = bus.wb_we && (bus.wb_addr == rt);
  assign imm_ext  = IMM_SIGNED ? {{10{instr_q[5]}}, instr_q[5:0]}
                               : {10'b0, instr_q[5:0]};

  assign bus.in_ready      = in_ready;
  assign bus.rf_readA_addr = rs;
  assign bus.rf_readB_addr = rt;
  assign bus.out_valid     = vld_q;
  assign bus.out_op        = op_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_opA       = opa_q;
  assign bus.out_opB       = opb_q;
  assign bus.out_imm       = imm_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = CAPT;
      CAPT:    state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = accept ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_d  = instr_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    pdat_a_d = pdat_a_q;
    pdat_b_d = pdat_b_q;
    vld_d    = vld_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    imm_d    = imm_q;

    if (accept) begin
      instr_d  = bus.instr;
      pend_a_d = 1'b0;
      pend_b_d = 1'b0;
    end

    case (state_q)
      // The file samples at this edge and returns pre-write data, so stash it.
      READ: begin
        if (hit_a) begin pend_a_d = 1'b1; pdat_a_d = bus.wb_data; end
        if (hit_b) begin pend_b_d = 1'b1; pdat_b_d = bus.wb_data; end
      end
      CAPT: begin
        op_d  = instr_q[15:12];
        rd_d  = instr_q[11:9];
        imm_d = imm_ext;
        opa_d = hit_a ? bus.wb_data : (pend_a_q ? pdat_a_q : bus.rf_reg_A);
        opb_d = hit_b ? bus.wb_data : (pend_b_q ? pdat_b_q : bus.rf_reg_B);
        vld_d = 1'b1;
      end
      HOLD: begin
        if (hit_a) opa_d = bus.wb_data;
        if (hit_b) opb_d = bus.wb_data;
        if (bus.out_ready) vld_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      pdat_a_q <= '0;
      pdat_b_q <= '0;
      vld_q    <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      pdat_a_q <= pdat_a_d;
      pdat_b_q <= pdat_b_d;
      vld_q    <= vld_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      imm_q    <= imm_d;
    end
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Sits between the instruction register and the ALU in the multi-cycle datapath.
- Accepts one 16-bit instruction over a valid/ready handshake and drives the read addresses of the 8x16 register file.
- That register file has a synchronous read: addresses are sampled on the CLK edge and data is valid the cycle after.
- This stage waits out that read latency, captures both operands, and forwards any write-port activity that the file's old-data read would miss. It then presents a decoded operand bundle downstream with valid/ready.

Parameters:
- IMM_SIGNED, 1, 1: imm6 is sign-extended to 16 bits; 0: imm6 is zero-extended.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage can accept instr
- instr  in  16  fields: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0]
- rf_readA_addr  out  3  register file read address A (= latched rs)
- rf_readB_addr  out  3  register file read address B (= latched rt)
- rf_reg_A  in  16  register file output A (valid one cycle after address is sampled)
- rf_reg_B  in  16  register file output B
- wb_we  in  1  snoop of register file write enable (same net)
- wb_addr  in  3  snoop of register file write address
- wb_data  in  16  snoop of register file write value
- out_valid  out  1  operand bundle valid
- out_ready  in  1  downstream accepts bundle
- out_op  out  4  opcode
- out_rd  out  3  destination register
- out_opA  out  16  operand A
- out_opB  out  16  operand B
- out_imm  out  16  extended immediate

Behaviour:
- Reset is asynchronous on RST_N low and applies mid-operation too. All outputs and internal registers go to 0, state goes to IDLE, and any in-flight instruction is dropped.
- States and transitions:
  - IDLE: in_ready=1. On in_valid, latch instr and go to READ.
  - READ: rf addresses are stable and the file samples them at this edge. Go to CAPT.
  - CAPT: rf_reg_A/B carry the read data. At this edge, load out_opA/B with bypass applied (below). Go to HOLD.
  - HOLD: out_valid=1. On out_ready, the bundle transfers. If in_valid is also high in the same cycle, latch the new instr and go to READ; otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational and is the only combinational output besides the rf addresses.
- The latched instruction register changes only when in_valid && in_ready.
- Latency and throughput:
  - Bundle is valid 3 edges after acceptance.
  - Peak throughput is 1 instruction per 3 cycles.
- rf_readA_addr/rf_readB_addr come from the latched instruction and hold their value in every state. Reset value is 0.
- out_op, out_rd and out_imm load at the CAPT edge.
- out_imm = {{10{imm6[5]}}, imm6} when IMM_SIGNED=1, else {10'b0, imm6}.
- Bypass rules:
  - A register file write at the READ edge returns old data. A write at the CAPT edge is not seen at all.
  - Hold per-operand pending flags and pending data, cleared on acceptance.
  - On each edge in READ, if wb_we && wb_addr==rs, record wb_data for A. Apply the same rule for rt and B.
  - At the CAPT edge, out_opA is chosen in priority order:
    1. wb_data, if wb_we && wb_addr==rs at that same edge;
    2. the pending A data, if the A flag is set;
    3. rf_reg_A.
  - Operand B follows the same rule with rt.
  - In HOLD, any wb_we with wb_addr==rs overwrites out_opA, and wb_addr==rt overwrites out_opB. This keeps the held bundle coherent.
  - rs==rt: both operands update from one write.
- Register 0 gets no special treatment.
- out_valid, once set, stays high and the bundle stays stable until out_ready is seen. The only exception is bypass updates in HOLD.

Test Plan:
- Basic fetch: preload R2=0x1234 and R5=0xBEEF, send instr 0x1AA8 (op=1, rd=5, rs=2, rt=5, imm=0x28). Required: out_valid rises exactly 3 edges after acceptance, out_opA=0x1234, out_opB=0xBEEF, out_rd=5, out_imm=0xFFE8.
- Same-edge hazard: R3=0x0001; write R3=0x00FF at the READ edge while rs=3. Required: out_opA=0x00FF, not 0x0001.
- Late write: write R4=0xA5A5 at the CAPT edge with rt=4. Required: out_opB=0xA5A5. A second write of R4=0x5A5A in HOLD then changes out_opB to 0x5A5A.
- Back-pressure and back-to-back: hold out_ready=0 for 5 cycles. Required: bundle stable, in_ready=0. Then raise out_ready with in_valid high. Required: new instr accepted in the same cycle and the next out_valid 3 edges later.
- Reset mid-operation: assert RST_N=0 during CAPT. Required: out_valid=0, in_ready=1 after release, rf addresses=0, no bundle emitted. IMM_SIGNED=0 variant: imm6=0x28 gives out_imm=0x0028.
